// File: rtl/clock_maker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_maker_pkg
// Description : Shared constants and helpers for the programmable clock
//               maker: reset defaults (divide-by-5, 2 cycles high), default
//               counter width and the channel-select width function.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_maker_pkg;

    localparam int C_CNT_WIDTH      = 8;
    localparam int C_DEFAULT_PERIOD = 5;
    localparam int C_DEFAULT_HIGH   = 2;

    // Width of a channel select able to address n channels, never below 1.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : clock_maker_pkg
`default_nettype wire

// File: rtl/divider_channel.sv
`default_nettype none
// ============================================================================
// Module      : divider_channel
// Description : One programmable clock divider. Holds a phase counter, the
//               active and pending period/high-time registers, and the
//               registered clock and period-tick outputs. Pending settings
//               move to the active set only at a period boundary.
// Ports       : clk, rst          - reference clock, async active-high reset
//               i_enable          - run enable
//               i_load            - write pending period/high this edge
//               i_load_period     - new period D
//               i_load_high       - new high time H
//               i_sync            - restart at phase 0 (running only)
//               o_clk             - divided clock
//               o_tick            - high for the cycle at phase 0
// Revision    : 1.0 - initial release
// ============================================================================
module divider_channel #(
    parameter int CNT_WIDTH      = 8,
    parameter int DEFAULT_PERIOD = 5,
    parameter int DEFAULT_HIGH   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_enable,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] i_load_period,
    input  logic [CNT_WIDTH-1:0] i_load_high,
    input  logic                 i_sync,
    output logic                 o_clk,
    output logic                 o_tick
);

    localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] C_TWO = CNT_WIDTH'(2);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_per_act;
    logic [CNT_WIDTH-1:0] r_high_act;
    logic [CNT_WIDTH-1:0] r_per_pend;
    logic [CNT_WIDTH-1:0] r_high_pend;
    logic                 r_clk;
    logic                 r_tick;

    logic                 w_running;
    logic                 w_wrap;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic                 w_boundary;
    logic [CNT_WIDTH-1:0] w_high_eff;

    // A period of 0 or 1 cannot toggle, so such a channel is parked.
    assign w_running  = i_enable && (r_per_act >= C_TWO);
    assign w_wrap     = (r_cnt == (r_per_act - C_ONE)) || i_sync;
    assign w_cnt_next = w_wrap ? '0 : (r_cnt + C_ONE);
    assign w_boundary = (w_cnt_next == '0);
    // At a boundary the output already follows the high time being loaded,
    // so the first cycle of a new period uses the new duty cycle.
    assign w_high_eff = w_boundary ? r_high_pend : r_high_act;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= CNT_WIDTH'(DEFAULT_PERIOD - 1);
            r_per_act   <= CNT_WIDTH'(DEFAULT_PERIOD);
            r_high_act  <= CNT_WIDTH'(DEFAULT_HIGH);
            r_per_pend  <= CNT_WIDTH'(DEFAULT_PERIOD);
            r_high_pend <= CNT_WIDTH'(DEFAULT_HIGH);
            r_clk       <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            if (i_load) begin
                r_per_pend  <= i_load_period;
                r_high_pend <= i_load_high;
            end
            // Active registers always take the pre-edge pending values, so a
            // load landing on a boundary edge waits for the following one.
            if (w_running) begin
                r_cnt  <= w_cnt_next;
                r_clk  <= (w_cnt_next < w_high_eff);
                r_tick <= w_boundary;
                if (w_boundary) begin
                    r_per_act  <= r_per_pend;
                    r_high_act <= r_high_pend;
                end
            end else begin
                // Parked at the last phase so the first enabled edge wraps to
                // phase 0 and produces a rising edge with a tick.
                r_cnt      <= r_per_pend - C_ONE;
                r_per_act  <= r_per_pend;
                r_high_act <= r_high_pend;
                r_clk      <= 1'b0;
                r_tick     <= 1'b0;
            end
        end
    end

    assign o_clk  = r_clk;
    assign o_tick = r_tick;

endmodule : divider_channel
`default_nettype wire

// File: rtl/programmable_clock_maker.sv
`default_nettype none
// ============================================================================
// Module      : programmable_clock_maker
// Description : Bank of CHANNELS independent glitch-free programmable clock
//               dividers from one reference clock. Decodes the load channel
//               select and fans the sync strobe out to every channel.
// Ports       : ref_clock, reset  - reference clock, async active-high reset
//               enable            - per-channel run enable
//               load, load_channel- settings write strobe and target channel
//               load_period/high  - new period and high time
//               sync              - phase-align all running channels
//               clk_out           - divided clocks
//               period_tick       - per-channel phase-0 tick
// Revision    : 1.0 - initial release
// ============================================================================
module programmable_clock_maker
    import clock_maker_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int CNT_WIDTH      = C_CNT_WIDTH,
    parameter int DEFAULT_PERIOD = C_DEFAULT_PERIOD,
    parameter int DEFAULT_HIGH   = C_DEFAULT_HIGH,
    parameter int SEL_WIDTH      = sel_width(CHANNELS)
) (
    input  logic                 ref_clock,
    input  logic                 reset,
    input  logic [CHANNELS-1:0]  enable,
    input  logic                 load,
    input  logic [SEL_WIDTH-1:0] load_channel,
    input  logic [CNT_WIDTH-1:0] load_period,
    input  logic [CNT_WIDTH-1:0] load_high,
    input  logic                 sync,
    output logic [CHANNELS-1:0]  clk_out,
    output logic [CHANNELS-1:0]  period_tick
);

    logic [CHANNELS-1:0] w_load_sel;

    // Select values at or above CHANNELS match no channel and are dropped.
    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
            assign w_load_sel[g] = load && (load_channel == SEL_WIDTH'(g));

            divider_channel #(
                .CNT_WIDTH      (CNT_WIDTH),
                .DEFAULT_PERIOD (DEFAULT_PERIOD),
                .DEFAULT_HIGH   (DEFAULT_HIGH)
            ) u_channel (
                .clk           (ref_clock),
                .rst           (reset),
                .i_enable      (enable[g]),
                .i_load        (w_load_sel[g]),
                .i_load_period (load_period),
                .i_load_high   (load_high),
                .i_sync        (sync),
                .o_clk         (clk_out[g]),
                .o_tick        (period_tick[g])
            );
        end
    endgenerate

endmodule : programmable_clock_maker
`default_nettype wire

// File: tb/tb_programmable_clock_maker.sv
`default_nettype none
// ============================================================================
// Module      : tb_programmable_clock_maker
// Description : Directed self-checking bench for programmable_clock_maker
//               with four channels and a 3-bit select, so that an
//               out-of-range channel number can be driven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_programmable_clock_maker;

    logic       ref_clock;
    logic       reset;
    logic [3:0] enable;
    logic       load;
    logic [2:0] load_channel;
    logic [7:0] load_period;
    logic [7:0] load_high;
    logic       sync;
    logic [3:0] clk_out;
    logic [3:0] period_tick;

    int n_checks = 0;
    int n_errors = 0;

    programmable_clock_maker #(
        .CHANNELS       (4),
        .CNT_WIDTH      (8),
        .DEFAULT_PERIOD (5),
        .DEFAULT_HIGH   (2),
        .SEL_WIDTH      (3)
    ) dut (
        .ref_clock    (ref_clock),
        .reset        (reset),
        .enable       (enable),
        .load         (load),
        .load_channel (load_channel),
        .load_period  (load_period),
        .load_high    (load_high),
        .sync         (sync),
        .clk_out      (clk_out),
        .period_tick  (period_tick)
    );

    initial begin
        ref_clock = 1'b0;
        forever #5 ref_clock = ~ref_clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic wait_edge();
        @(posedge ref_clock);
        #1;
    endtask

    // One edge, then compare all four channels (bit order ch3..ch0).
    task automatic step(input string tag, input logic [3:0] ec, input logic [3:0] et);
        wait_edge();
        check({tag, ".clk"}, clk_out, ec);
        check({tag, ".tick"}, period_tick, et);
    endtask

    // One edge, then compare channel 0 only.
    task automatic step0(input string tag, input logic ec, input logic et);
        wait_edge();
        check({tag, ".clk0"}, {3'b000, clk_out[0]}, {3'b000, ec});
        check({tag, ".tick0"}, {3'b000, period_tick[0]}, {3'b000, et});
    endtask

    task automatic set_load(input logic [2:0] ch, input logic [7:0] d, input logic [7:0] h);
        load         = 1'b1;
        load_channel = ch;
        load_period  = d;
        load_high    = h;
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 4'hF;
        load         = 1'b0;
        load_channel = 3'd0;
        load_period  = 8'd0;
        load_high    = 8'd0;
        sync         = 1'b0;

        // Reset state
        wait_edge();
        wait_edge();
        check("reset.clk", clk_out, 4'h0);
        check("reset.tick", period_tick, 4'h0);
        reset = 1'b0;

        // Defaults: 1,1,0,0,0 repeating, tick on each first 1
        for (int i = 0; i < 10; i++)
            step("dflt", ((i % 5) < 2) ? 4'hF : 4'h0, ((i % 5) == 0) ? 4'hF : 4'h0);

        // ch1 D=8 H=3 loaded mid-period (phase 2)
        step("mid0", 4'hF, 4'hF);
        step("mid1", 4'hF, 4'h0);
        set_load(3'd1, 8'd8, 8'd3);
        step("mid2", 4'h0, 4'h0);
        load = 1'b0;
        step("mid3",  4'h0,    4'h0);
        step("mid4",  4'h0,    4'h0);
        step("mid5",  4'hF,    4'hF);
        step("mid6",  4'hF,    4'h0);
        step("mid7",  4'b0010, 4'h0);
        step("mid8",  4'h0,    4'h0);
        step("mid9",  4'h0,    4'h0);
        step("mid10", 4'b1101, 4'b1101);
        step("mid11", 4'b1101, 4'h0);
        step("mid12", 4'h0,    4'h0);
        step("mid13", 4'b0010, 4'b0010);

        // ch2 D=4 H=2 loaded on its boundary edge
        step("bnd0", 4'b0010, 4'h0);
        set_load(3'd2, 8'd4, 8'd2);
        step("bnd1", 4'hF, 4'b1101);
        load = 1'b0;
        step("bnd2",  4'b1101, 4'h0);
        step("bnd3",  4'h0,    4'h0);
        step("bnd4",  4'h0,    4'h0);
        step("bnd5",  4'h0,    4'h0);
        step("bnd6",  4'b1101, 4'b1101);
        step("bnd7",  4'hF,    4'b0010);
        step("bnd8",  4'b0010, 4'h0);
        step("bnd9",  4'b0010, 4'h0);
        step("bnd10", 4'b0100, 4'b0100);

        // ch1 D=6 H=3, ch2 D=7 H=3, then sync
        set_load(3'd1, 8'd6, 8'd3);
        wait_edge();
        set_load(3'd2, 8'd7, 8'd3);
        wait_edge();
        load = 1'b0;
        wait_edge();
        wait_edge();
        sync = 1'b1;
        step("sync0", 4'hF, 4'hF);
        sync = 1'b0;
        step("sync1", 4'hF,    4'h0);
        step("sync2", 4'b0110, 4'h0);
        step("sync3", 4'h0,    4'h0);
        step("sync4", 4'h0,    4'h0);
        step("sync5", 4'b1001, 4'b1001);
        step("sync6", 4'b1011, 4'b0010);
        step("sync7", 4'b0110, 4'b0100);

        // ch0 D=1 parks it; D=3 H=1 restarts it
        set_load(3'd0, 8'd1, 8'd0);
        step0("d1a", 1'b0, 1'b0);
        load = 1'b0;
        step0("d1b", 1'b0, 1'b0);
        step0("d1c", 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            step0("d1off", 1'b0, 1'b0);
        set_load(3'd0, 8'd3, 8'd1);
        step0("d3a", 1'b0, 1'b0);
        load = 1'b0;
        step0("d3b", 1'b0, 1'b0);
        step0("d3c", 1'b1, 1'b1);
        step0("d3d", 1'b0, 1'b0);
        step0("d3e", 1'b0, 1'b0);
        step0("d3f", 1'b1, 1'b1);

        // ch3 H=0, ch2 H=9 D=6, out-of-range select 5, then sync
        set_load(3'd3, 8'd4, 8'd0);
        wait_edge();
        set_load(3'd2, 8'd6, 8'd9);
        wait_edge();
        set_load(3'd5, 8'd2, 8'd1);
        wait_edge();
        load = 1'b0;
        sync = 1'b1;
        step("edge0", 4'b0111, 4'hF);
        sync = 1'b0;
        step("edge1", 4'b0110, 4'h0);
        step("edge2", 4'b0110, 4'h0);
        step("edge3", 4'b0101, 4'b0001);
        step("edge4", 4'b0100, 4'b1000);
        step("edge5", 4'b0100, 4'h0);
        step("edge6", 4'b0111, 4'b0111);
        step("edge7", 4'b0110, 4'h0);

        // Asynchronous reset mid-period
        #3;
        reset = 1'b1;
        #1;
        check("areset.clk", clk_out, 4'h0);
        check("areset.tick", period_tick, 4'h0);
        wait_edge();
        reset = 1'b0;
        step("rdf0", 4'hF, 4'hF);
        step("rdf1", 4'hF, 4'h0);
        step("rdf2", 4'h0, 4'h0);
        step("rdf3", 4'h0, 4'h0);
        step("rdf4", 4'h0, 4'h0);
        step("rdf5", 4'hF, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_programmable_clock_maker
`default_nettype wire
